// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: multi-cycle WIDTH-bit add/subtract built around a
// single 4-bit carry-lookahead adder, processing one nibble per cycle, LSB
// nibble first, with the carry chained through a register.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand request handshake (op_a, op_b, sub)
//   out_valid / out_ready result handshake (result, carry_out, overflow)
//   sub                   0: op_a + op_b, 1: op_a - op_b
//   carry_out             final nibble carry; for subtract 1 means no borrow
//   overflow              two's-complement signed overflow
//   busy                  high while an operation is in RUN or DONE

// cla_adder: 4-bit carry-lookahead adder.
//   a, b, cin -> sum, cout
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_n;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    bit_lo;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last;
  logic             accept;

  assign bit_lo = {idx, 2'b00};
  assign last   = (idx == IW'(NIB - 1));
  // in_ready is a registered image of state==IDLE, so this is the accept edge.
  assign accept = (state == IDLE) && in_valid && in_ready;

  cla_adder u_cla (
    .a    (a_r[bit_lo +: 4]),
    .b    (b_r[bit_lo +: 4]),
    .cin  (carry_r),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_n = RUN;
      RUN:     if (last)                 state_n = DONE;
      DONE:    if (out_ready)            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they line
  // up with the state register without any combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        // Subtract as a + ~b + 1: invert b once here and seed the carry.
        a_r     <= op_a;
        b_r     <= sub ? ~op_b : op_b;
        carry_r <= sub;
        idx     <= '0;
        result  <= '0;
      end else if (state == RUN) begin
        result[bit_lo +: 4] <= nib_sum;
        carry_r             <= nib_cout;
        idx                 <= idx + IW'(1);
        if (last) begin
          carry_out <= nib_cout;
          overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[3] != a_r[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        busy;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic, no nibble structure.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sb;
    int   rs;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    rs   = s ? (sa - sb) : (sa + sb);
    e.r  = s ? (a - b) : (a + b);
    e.c  = s ? (a >= b) : ((32'(a) + 32'(b)) > 32'd65535);
    e.v  = (rs > 32767) || (rs < -32768);
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v);
    exp_t e;
    e.r = r; e.c = c; e.v = v;
    return e;
  endfunction

  // Scoreboard consumer: a result is taken on the edge after this sample.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(result), 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.r));
        check("carry_out", 32'(carry_out), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("busy_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input exp_t e, input bit track);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_cyc = cyc;
      if (track) exp_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          acc[3];
    logic [15:0] ta;
    logic [15:0] tb;
    logic        ts;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Basic add with latency measurement.
    send(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0), 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    wait_drain();

    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b1);
    send(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b1);
    send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1'b1);
    send(16'h0000, 16'h8000, 1'b1, mk(16'h8000, 1'b0, 1'b1), 1'b1);
    send(16'hA5C3, 16'h0000, 1'b1, mk(16'hA5C3, 1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 6; i++) begin
      ta = 16'($urandom); tb = 16'($urandom); ts = 1'($urandom);
      send(ta, tb, ts, model(ta, tb, ts), 1'b1);
    end
    wait_drain();

    // Backpressure with input noise during RUN and DONE.
    @(negedge clk); out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b1, mk(16'h3210, 1'b1, 1'b0), 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      op_a = 16'($urandom); op_b = 16'($urandom); sub = ~sub; in_valid = ~in_valid;
      lat++;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op_a = 16'($urandom); in_valid = ~in_valid;
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'(result), 32'h3210);
      check("bp_flags", {30'd0, carry_out, overflow}, 32'd2);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    wait_drain();

    // Back-to-back with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      ta = 16'h1000 * 16'(k + 1) + 16'h0321; tb = 16'h0F0F; ts = 1'(k);
      op_a = ta; op_b = tb; sub = ts;
      n = 0;
      if (k > 0) @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      acc[k] = cyc;
      exp_q.push_back(model(ta, tb, ts));
      #1;
    end
    @(negedge clk); in_valid = 1'b0;
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd6);
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd6);
    wait_drain();

    // Reset mid-RUN, leaving a live carry in the chain.
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0), 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit add/subtract engine that sits directly upstream of the team's 4-bit cla_adder.
- It instantiates one cla_adder (a[3:0], b[3:0], cin -> sum[3:0], cout) and feeds it one operand nibble per cycle, LSB nibble first. It chains the carry through a register and collects each returned sum nibble into a WIDTH-bit result.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and >= 8; any other value is an elaboration error.
- NIB, WIDTH/4, number of nibble cycles per operation. Derived; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand request.
- op_a  input  WIDTH  first operand.
- op_b  input  WIDTH  second operand.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  final nibble cout. For sub: 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; result=0; carry_out=0; overflow=0; busy=0; nibble index and carry register cleared.
- Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: capture a_r=op_a, b_r=(sub ? ~op_b : op_b), carry_r=sub, idx=0, clear result; go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored and op_* may change freely.
  - Each cycle drives the cla_adder with a_r[4*idx+:4], b_r[4*idx+:4], cin=carry_r.
  - Each edge writes sum into result[4*idx+:4], sets carry_r=cout, and increments idx.
  - On the edge where idx==NIB-1, go to DONE. On that same edge:
    - carry_out=cout.
    - overflow=(a_r[WIDTH-1]==b_r[WIDTH-1]) && (sum[3]!=a_r[WIDTH-1]).
- DONE:
  - out_valid=1. result, carry_out and overflow are held stable.
  - On an edge with out_valid&out_ready, go to IDLE and clear out_valid.
  - No combinational path from out_ready to in_ready.
- Latency: accept edge T0; nibbles are processed on edges T1..TNIB; out_valid is high from TNIB to the consume edge.
- Throughput: one operation per NIB+2 cycles minimum. The IDLE cycle after consume is mandatory.
- result is not guaranteed meaningful while out_valid=0, but it changes only in RUN.
- Wrap-around: arithmetic is modulo 2^WIDTH.
- sub=1 with op_b=0: ~0 + 1 carry gives result=op_a, carry_out=1, overflow=0.
- Subtracting the most-negative value:
  - 0 - 0x8000 gives 0x8000 with overflow=1.
- in_valid held high across operations: exactly one capture per IDLE visit.
- All outputs are registered.

Test Plan:
- Add (WIDTH=16): a=0x1234, b=0x0FFF, sub=0 -> result=0x2233, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0001 -> 0x8000, carry_out=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, carry_out=0 (borrow), overflow=0. Then a=0x8000, b=0x0001 -> 0x7FFF, carry_out=1, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in DONE -> out_valid, result and flags stay stable; in_ready=0 throughout.
  - Toggle op_a and in_valid during RUN and DONE -> result is unaffected.
- Back-to-back: keep in_valid=1 with 3 queued operands -> each is accepted only in IDLE, spaced NIB+2=6 cycles apart when out_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 nibble edges -> immediately out_valid=0, in_ready=1, result=0. A new operation after release completes correctly, with no carry residue.
